// File: rtl/riscv_decode_stage_pkg.sv
// rtl/riscv_decode_stage_pkg.sv - shared RV32I instruction enums, opcodes and decoded-instruction struct
package riscv_decode_stage_pkg;

   typedef enum logic [5:0] {
      LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      NOP, FENCE, FENCEI, ECALL, EBREAK,
      CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
   } riscv_instr_name_t;

   typedef enum logic [2:0] {
      J_FORMAT, U_FORMAT, I_FORMAT, B_FORMAT, R_FORMAT, S_FORMAT, I_FORMAT_SHIFT
   } riscv_instr_format_t;

   typedef enum logic [3:0] {
      LOAD, STORE, SHIFT, ARITHMETIC, LOGICAL, COMPARE, BRANCH, JUMP,
      SYNCH, SYSTEM, COUNTER, CSR, CHANGELEVEL, TRAP, INTERRUPT
   } riscv_instr_cateogry_t;

   typedef enum logic [4:0] {
      ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1,
      A0, A1, A2, A3, A4, A5, A6, A7,
      S2, S3, S4, S5, S6, S7, S8, S9, S10, S11,
      T3, T4, T5, T6
   } riscv_reg_t;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      riscv_instr_name_t     name;
      riscv_instr_format_t   format;
      riscv_instr_cateogry_t category;
      riscv_reg_t            rd;
      riscv_reg_t            rs1;
      riscv_reg_t            rs2;
      logic [31:0]           imm;
      logic                  illegal;
   } riscv_decoded_t;

   localparam riscv_decoded_t DECODED_RESET = '{name: NOP, format: I_FORMAT, category: ARITHMETIC,
                                                rd: ZERO, rs1: ZERO, rs2: ZERO, imm: 32'h0,
                                                illegal: 1'b0};

endpackage

// File: rtl/riscv_decode_stage_decoder.sv
// rtl/riscv_decode_stage_decoder.sv - combinational RV32I decoder (CSR ops enabled by RISCV_DECODE_CSR_EN)
module riscv_instr_decoder
   import riscv_decode_stage_pkg::*;
(
   input  logic [31:0]    in_instr,
   output riscv_decoded_t decoded
);

   logic [6:0]            opcode, funct7;
   logic [2:0]            funct3;
   logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic                  legal, use_rd, use_rs1, use_rs2;
   riscv_instr_name_t     name;
   riscv_instr_format_t   fmt;
   riscv_instr_cateogry_t cat;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      legal   = 1'b1;
      name    = NOP;
      fmt     = I_FORMAT;
      cat     = ARITHMETIC;
      use_rd  = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      imm     = imm_i;
      case (opcode)
         OPC_LUI:   begin name = LUI;   fmt = U_FORMAT; use_rs1 = 1'b0; imm = imm_u; end
         OPC_AUIPC: begin name = AUIPC; fmt = U_FORMAT; use_rs1 = 1'b0; imm = imm_u; end
         OPC_JAL:   begin name = JAL;   fmt = J_FORMAT; cat = JUMP; use_rs1 = 1'b0; imm = imm_j; end
         OPC_JALR:  begin name = JALR;  cat = JUMP; legal = (funct3 == 3'b000); end
         OPC_BRANCH: begin
            fmt = B_FORMAT; cat = BRANCH; use_rd = 1'b0; use_rs2 = 1'b1; imm = imm_b;
            case (funct3)
               3'b000:  name = BEQ;
               3'b001:  name = BNE;
               3'b100:  name = BLT;
               3'b101:  name = BGE;
               3'b110:  name = BLTU;
               3'b111:  name = BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            cat = LOAD;
            case (funct3)
               3'b000:  name = LB;
               3'b001:  name = LH;
               3'b010:  name = LW;
               3'b100:  name = LBU;
               3'b101:  name = LHU;
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            fmt = S_FORMAT; cat = STORE; use_rd = 1'b0; use_rs2 = 1'b1; imm = imm_s;
            case (funct3)
               3'b000:  name = SB;
               3'b001:  name = SH;
               3'b010:  name = SW;
               default: legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            case (funct3)
               3'b000:  name = (in_instr == 32'h0000_0013) ? NOP : ADDI;
               3'b010:  begin name = SLTI;  cat = COMPARE; end
               3'b011:  begin name = SLTIU; cat = COMPARE; end
               3'b100:  begin name = XORI;  cat = LOGICAL; end
               3'b110:  begin name = ORI;   cat = LOGICAL; end
               3'b111:  begin name = ANDI;  cat = LOGICAL; end
               default: begin
                  // shift-immediate: shamt is unsigned, funct7 selects logical/arithmetic
                  fmt  = I_FORMAT_SHIFT; cat = SHIFT; imm = {27'b0, in_instr[24:20]};
                  name = (funct3 == 3'b001) ? SLLI : (funct7[5] ? SRAI : SRLI);
                  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000 && funct3 == 3'b101);
               end
            endcase
         end
         OPC_OP: begin
            fmt = R_FORMAT; use_rs2 = 1'b1; imm = 32'h0;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  name = ADD;
                  3'b001:  begin name = SLL;  cat = SHIFT;   end
                  3'b010:  begin name = SLT;  cat = COMPARE; end
                  3'b011:  begin name = SLTU; cat = COMPARE; end
                  3'b100:  begin name = XOR;  cat = LOGICAL; end
                  3'b101:  begin name = SRL;  cat = SHIFT;   end
                  3'b110:  begin name = OR;   cat = LOGICAL; end
                  default: begin name = AND;  cat = LOGICAL; end
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               name = SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               name = SRA; cat = SHIFT;
            end else begin
               legal = 1'b0;
            end
         end
         OPC_MISC_MEM: begin
            cat = SYNCH;
            case (funct3)
               3'b000:  name = FENCE;
               3'b001:  name = FENCEI;
               default: legal = 1'b0;
            endcase
         end
         OPC_SYSTEM: begin
            cat = SYSTEM;
            if (in_instr == 32'h0000_0073)      name = ECALL;
            else if (in_instr == 32'h0010_0073) name = EBREAK;
`ifdef RISCV_DECODE_CSR_EN
            else begin
               cat = CSR; imm = {20'b0, in_instr[31:20]};
               case (funct3)
                  3'b001:  name = CSRRW;
                  3'b010:  name = CSRRS;
                  3'b011:  name = CSRRC;
                  3'b101:  name = CSRRWI;
                  3'b110:  name = CSRRSI;
                  3'b111:  name = CSRRCI;
                  default: legal = 1'b0;
               endcase
            end
`else
            else legal = 1'b0;
`endif
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      decoded = DECODED_RESET;
      if (legal) begin
         decoded.name     = name;
         decoded.format   = fmt;
         decoded.category = cat;
         decoded.rd       = use_rd  ? riscv_reg_t'(in_instr[11:7])  : ZERO;
         decoded.rs1      = use_rs1 ? riscv_reg_t'(in_instr[19:15]) : ZERO;
         decoded.rs2      = use_rs2 ? riscv_reg_t'(in_instr[24:20]) : ZERO;
         decoded.imm      = imm;
      end else begin
         decoded.category = TRAP;
         decoded.illegal  = 1'b1;
      end
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - RV32I decode stage with two-entry output buffer and illegal counter (RISCV_DECODE_CSR_EN in decoder)
module riscv_decode_stage
   import riscv_decode_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [XLEN-1:0]       in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [31:0]           out_instr,
   output riscv_instr_name_t     out_name,
   output riscv_instr_format_t   out_format,
   output riscv_instr_cateogry_t out_category,
   output riscv_reg_t            out_rd,
   output riscv_reg_t            out_rs1,
   output riscv_reg_t            out_rs2,
   output logic [31:0]           out_imm,
   output logic                  out_illegal,
   output logic [CNT_W-1:0]      illegal_cnt
);

   typedef struct packed {
      riscv_decoded_t  dec;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   localparam entry_t ENTRY_RESET = '{dec: DECODED_RESET, pc: '0, instr: '0};

   riscv_decoded_t dec;
   entry_t         in_entry, out_q, skid_q;
   logic           out_vld, skid_vld, in_fire, out_fire;

   riscv_instr_decoder u_decoder (
      .in_instr (in_instr),
      .decoded  (dec)
   );

   assign in_entry = '{dec: dec, pc: in_pc, instr: in_instr};
   assign in_ready = !skid_vld;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_vld && out_ready;

   // skid only fills while the output register is stalled, so in_ready never depends on out_ready combinationally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         out_q    <= ENTRY_RESET;
         skid_q   <= ENTRY_RESET;
      end else if (flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!out_vld || out_fire) begin
         if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else if (in_fire) begin
            out_q   <= in_entry;
            out_vld <= 1'b1;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (in_fire) begin
         skid_q   <= in_entry;
         skid_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         illegal_cnt <= '0;
      else if (in_fire && !flush && dec.illegal && illegal_cnt != '1)
         illegal_cnt <= illegal_cnt + CNT_W'(1);
   end

   assign out_valid    = out_vld;
   assign out_pc       = out_q.pc;
   assign out_instr    = out_q.instr;
   assign out_name     = out_q.dec.name;
   assign out_format   = out_q.dec.format;
   assign out_category = out_q.dec.category;
   assign out_rd       = out_q.dec.rd;
   assign out_rs1      = out_q.dec.rs1;
   assign out_rs2      = out_q.dec.rs2;
   assign out_imm      = out_q.dec.imm;
   assign out_illegal  = out_q.dec.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - scoreboard bench for riscv_decode_stage
module tb_riscv_decode_stage;
   import riscv_decode_stage_pkg::*;

   localparam int CNT_W = 3;

   logic                  clk = 1'b0;
   logic                  rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0]           in_instr, in_pc, out_pc, out_instr, out_imm;
   riscv_instr_name_t     out_name;
   riscv_instr_format_t   out_format;
   riscv_instr_cateogry_t out_category;
   riscv_reg_t            out_rd, out_rs1, out_rs2;
   logic [CNT_W-1:0]      illegal_cnt;

   typedef struct packed {
      logic [31:0]           pc;
      logic [31:0]           instr;
      riscv_instr_name_t     name;
      riscv_instr_format_t   fmt;
      riscv_instr_cateogry_t cat;
      riscv_reg_t            rd, rs1, rs2;
      logic [31:0]           imm;
      logic                  ill;
   } exp_t;

   exp_t             sb[$];
   exp_t             act, e;
   int               n_cmp = 0, n_bad = 0, n_acc = 0, base;
   logic [CNT_W-1:0] exp_cnt = '0;

   riscv_decode_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_name(out_name), .out_format(out_format), .out_category(out_category),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
      .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] req);
      n_cmp++;
      if (actual !== req) begin
         n_bad++;
         $display("FAIL %s actual %h required %h", nm, actual, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input riscv_instr_name_t n, input riscv_instr_format_t f,
                               input riscv_instr_cateogry_t c, input riscv_reg_t rd,
                               input riscv_reg_t rs1, input riscv_reg_t rs2, input logic [31:0] imm);
      return '{pc, instr, n, f, c, rd, rs1, rs2, imm, 1'b0};
   endfunction

   function automatic exp_t mk_ill(input logic [31:0] pc, input logic [31:0] instr);
      return '{pc, instr, NOP, I_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1};
   endfunction

   // monitor: every output transfer must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         act = '{out_pc, out_instr, out_name, out_format, out_category,
                 out_rd, out_rs1, out_rs2, out_imm, out_illegal};
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output actual %h required none", act);
         end else begin
            e = sb.pop_front();
            if (act !== e) begin
               n_bad++;
               $display("FAIL out_payload pc=%h actual %h required %h", e.pc, act, e);
            end
         end
      end
   end

   task automatic send(input exp_t x);
      in_valid = 1'b1; in_instr = x.instr; in_pc = x.pc;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(x);
            n_acc++;
            if (x.ill && exp_cnt != '1) exp_cnt++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
      end
      n_cmp++; n_bad++;
      $display("FAIL send_timeout pc=%h actual in_ready=0 required 1", x.pc);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_queue_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cnt", illegal_cnt, 0);
      chk("rst_name", 32'(out_name), 32'(NOP));
      chk("rst_format", 32'(out_format), 32'(I_FORMAT));
      chk("rst_category", 32'(out_category), 32'(ARITHMETIC));
      chk("rst_rd", 32'(out_rd), 32'(ZERO));
      chk("rst_imm", out_imm, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_illegal", out_illegal, 0);
      rst = 1'b0;

      // directed decode vectors, streamed with out_ready high
      send(mk(32'h100, 32'h0000_0013, NOP, I_FORMAT, ARITHMETIC, ZERO, ZERO, ZERO, 32'h0));
      chk("latency_out_valid", out_valid, 1);
      send(mk(32'h104, 32'hFFF0_0093, ADDI, I_FORMAT, ARITHMETIC, RA, ZERO, ZERO, 32'hFFFF_FFFF));
      send(mk(32'h108, 32'h4010_D093, SRAI, I_FORMAT_SHIFT, SHIFT, RA, RA, ZERO, 32'h1));
`ifdef RISCV_DECODE_CSR_EN
      send(mk(32'h10C, 32'h3000_1073, CSRRW, I_FORMAT, CSR, ZERO, ZERO, ZERO, 32'h300));
`else
      send(mk_ill(32'h10C, 32'h3000_1073));
`endif
      send(mk_ill(32'h110, 32'h0000_0000));
      send(mk_ill(32'h114, 32'h0200_0033));
      send(mk(32'h118, 32'h0020_81B3, ADD, R_FORMAT, ARITHMETIC, GP, RA, SP, 32'h0));
      send(mk(32'h11C, 32'h4020_81B3, SUB, R_FORMAT, ARITHMETIC, GP, RA, SP, 32'h0));
      send(mk(32'h120, 32'hFE20_8EE3, BEQ, B_FORMAT, BRANCH, ZERO, RA, SP, 32'hFFFF_FFFC));
      send(mk(32'h124, 32'h0020_A423, SW, S_FORMAT, STORE, ZERO, RA, SP, 32'h8));
      send(mk(32'h128, 32'h1234_52B7, LUI, U_FORMAT, ARITHMETIC, T0, ZERO, ZERO, 32'h1234_5000));
      send(mk(32'h12C, 32'h0100_00EF, JAL, J_FORMAT, JUMP, RA, ZERO, ZERO, 32'h10));
      send(mk(32'h130, 32'h0000_0073, ECALL, I_FORMAT, SYSTEM, ZERO, ZERO, ZERO, 32'h0));
      send(mk_ill(32'h134, 32'h4020_91B3));
      drain();
      chk("stream_illegal_cnt", illegal_cnt, exp_cnt);

      // backpressure: only two words fit while out_ready is low
      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            send(mk(32'h200, 32'h0000_0013, NOP, I_FORMAT, ARITHMETIC, ZERO, ZERO, ZERO, 32'h0));
            send(mk(32'h204, 32'hFFF0_0093, ADDI, I_FORMAT, ARITHMETIC, RA, ZERO, ZERO, 32'hFFFF_FFFF));
            send(mk(32'h208, 32'h0020_81B3, ADD, R_FORMAT, ARITHMETIC, GP, RA, SP, 32'h0));
            send(mk(32'h20C, 32'h4010_D093, SRAI, I_FORMAT_SHIFT, SHIFT, RA, RA, ZERO, 32'h1));
         end
      join_none
      repeat (3) @(posedge clk); #2;
      chk("bp_accepted", n_acc - base, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 60 && (n_acc - base) < 4; i++) @(posedge clk);
      chk("bp_all_accepted", n_acc - base, 4);
      drain();

      // flush with both entries full and an input offered
      out_ready = 1'b0;
      send(mk(32'h300, 32'h0000_0013, NOP, I_FORMAT, ARITHMETIC, ZERO, ZERO, ZERO, 32'h0));
      send(mk(32'h304, 32'h0020_81B3, ADD, R_FORMAT, ARITHMETIC, GP, RA, SP, 32'h0));
      chk("full_in_ready", in_ready, 0);
      in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h308; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      sb.delete();
      // flush while in_ready is high must also discard the offered word
      in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h30C; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush2_out_valid", out_valid, 0);
      chk("flush_cnt", illegal_cnt, exp_cnt);
      out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      send(mk(32'h310, 32'h0020_A423, SW, S_FORMAT, STORE, ZERO, RA, SP, 32'h8));
      drain();

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      send(mk_ill(32'h400, 32'h0000_0000));
      chk("pre_reset_cnt", illegal_cnt, exp_cnt);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_cnt", illegal_cnt, 0);
      chk("async_rst_in_ready", in_ready, 1);
      sb.delete(); exp_cnt = '0;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;

      // counter saturation
      for (int k = 0; k < 9; k++) send(mk_ill(32'h500 + 32'(4 * k), 32'h0200_0033));
      drain();
      chk("sat_cnt", illegal_cnt, 3'b111);
      chk("final_out_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
